// File: rtl/edge_det_bank.sv
// Multi-channel synchronised, glitch-filtered edge detector with sticky flags and irq.
// Define EDGE_DET_BANK_CNT_EN to add per-channel saturating event counters on cnt_out.
module edge_det_bank #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     signal_in,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH-1:0]     irq_mask,
    input  logic [CH-1:0]     clr,
    output logic [CH-1:0]     edge_rdy,
    output logic [CH-1:0]     pending,
`ifdef EDGE_DET_BANK_CNT_EN
    output logic [8*CH-1:0]   cnt_out,
`endif
    output logic              irq
);

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [3:0]             stab_q [CH];
    logic [CH-1:0]          filt_q;
    logic [CH-1:0]          sync_out;
    logic [CH-1:0]          differ;
    logic [CH-1:0]          settle;
    logic [CH-1:0]          event_hit;

    always_comb begin
        sync_out  = '0;
        differ    = '0;
        settle    = '0;
        event_hit = '0;
        for (int i = 0; i < CH; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
            differ[i]   = sync_out[i] ^ filt_q[i];
            settle[i]   = differ[i] && ((stab_q[i] + 4'd1) == 4'(FILT_LEN));
            // New level 1 is a rise, new level 0 is a fall.
            event_hit[i] = settle[i] &&
                           ((sync_out[i] && mode[2*i]) ||
                            (!sync_out[i] && mode[2*i+1]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                stab_q[i] <= '0;
            end
            filt_q   <= '0;
            edge_rdy <= '0;
            pending  <= '0;
            irq      <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal_in[i]};
                if (!differ[i] || settle[i])
                    stab_q[i] <= '0;
                else
                    stab_q[i] <= stab_q[i] + 4'd1;
                if (settle[i])
                    filt_q[i] <= sync_out[i];
            end
            edge_rdy <= event_hit;
            // Setting from the registered pulse lets a coincident clr lose.
            pending  <= (pending & ~clr) | edge_rdy;
            irq      <= |(pending & irq_mask);
        end
    end

`ifdef EDGE_DET_BANK_CNT_EN
    logic [7:0] evc_q [CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++)
                evc_q[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (clr[i])
                    evc_q[i] <= {7'd0, edge_rdy[i]};
                else if (edge_rdy[i] && evc_q[i] != 8'hFF)
                    evc_q[i] <= evc_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < CH; i++)
            cnt_out[8*i +: 8] = evc_q[i];
    end
`endif

endmodule

// File: tb/tb_edge_det_bank.sv
// Directed self-checking bench for edge_det_bank (CH=4, SYNC_STAGES=2, FILT_LEN=3).
// Counter checks run when EDGE_DET_BANK_CNT_EN is defined.
module tb_edge_det_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] signal_in;
    logic [7:0] mode;
    logic [3:0] irq_mask;
    logic [3:0] clr;
    logic [3:0] edge_rdy;
    logic [3:0] pending;
    logic       irq;
`ifdef EDGE_DET_BANK_CNT_EN
    logic [31:0] cnt_out;
`endif

    int tests;
    int fails;

    edge_det_bank #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .mode      (mode),
        .irq_mask  (irq_mask),
        .clr       (clr),
        .edge_rdy  (edge_rdy),
        .pending   (pending),
`ifdef EDGE_DET_BANK_CNT_EN
        .cnt_out   (cnt_out),
`endif
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        signal_in = 4'b0000;
        mode      = 8'b11_10_11_01;
        irq_mask  = 4'b0001;
        clr       = 4'b0000;
        #1;
        tick(2);
        check("reset_edge", 32'(edge_rdy), 32'h0);
        check("reset_pend", 32'(pending), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        tick(3);
        check("idle_edge", 32'(edge_rdy), 32'h0);

        // Rise on ch0: pulse exactly at edge 5 after the first sampling edge
        signal_in[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rise_early", 32'(edge_rdy), 32'h0);
        end
        tick();
        check("rise_edge5", 32'(edge_rdy), 32'h1);
        tick();
        check("rise_1cyc", 32'(edge_rdy), 32'h0);
        check("rise_pend", 32'(pending), 32'h1);
        check("rise_irq_lag", 32'(irq), 32'h0);
        tick();
        check("rise_irq", 32'(irq), 32'h1);
        tick(5);
        check("rise_hold", 32'(edge_rdy), 32'h0);

        // 2-cycle glitch on ch1 (mode both) is filtered out
        signal_in[1] = 1'b1;
        tick(2);
        signal_in[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch_edge1", 32'(edge_rdy[1]), 32'h0);
        end
        check("glitch_pend1", 32'(pending[1]), 32'h0);

        // ch2 fall mode: the rise is ignored, the fall fires
        signal_in[2] = 1'b1;
        tick(8);
        check("fall_norise", 32'(pending[2]), 32'h0);
        signal_in[2] = 1'b0;
        tick(4);
        check("fall_early", 32'(edge_rdy[2]), 32'h0);
        tick();
        check("fall_edge", 32'(edge_rdy), 32'h4);
        clr = 4'b0100;
        tick();
        clr = 4'b0000;
        check("fall_clr_coin", 32'(pending[2]), 32'h1);
        tick(2);
        clr = 4'b0100;
        tick();
        clr = 4'b0000;
        check("fall_clr", 32'(pending[2]), 32'h0);

        // All channels both-edge, toggled together, irq masked off
        mode     = 8'hFF;
        irq_mask = 4'b0000;
        clr      = 4'b1111;
        tick();
        clr = 4'b0000;
        tick(2);
        check("all_pre_pend", 32'(pending), 32'h0);
        check("all_pre_irq", 32'(irq), 32'h0);
        signal_in = ~signal_in;
        tick(4);
        check("all_early", 32'(edge_rdy), 32'h0);
        tick();
        check("all_edge", 32'(edge_rdy), 32'hF);
        tick();
        check("all_pend", 32'(pending), 32'hF);
        tick(2);
        check("all_irq", 32'(irq), 32'h0);
        tick(4);

`ifdef EDGE_DET_BANK_CNT_EN
        clr = 4'b1111;
        tick();
        clr = 4'b0000;
        check("cnt_clr0", cnt_out, 32'h0);
        for (int k = 0; k < 300; k++) begin
            signal_in[3] = ~signal_in[3];
            tick(5);
        end
        tick(2);
        check("cnt_sat", 32'(cnt_out[31:24]), 32'hFF);
        check("cnt_others", 32'(cnt_out[23:0]), 32'h0);
        clr = 4'b1000;
        tick();
        clr = 4'b0000;
        check("cnt_clr3", 32'(cnt_out[31:24]), 32'h0);
        tick(2);
`endif

        // Reset two cycles into filtering discards the partial count
        signal_in = 4'b0000;
        tick(8);
        mode     = 8'b00_00_00_01;
        irq_mask = 4'b1111;
        signal_in[0] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        signal_in[0] = 1'b0;
        #2;
        check("rst_mid_edge", 32'(edge_rdy), 32'h0);
        check("rst_mid_pend", 32'(pending), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rst_post_edge", 32'(edge_rdy), 32'h0);
        end
        check("rst_post_pend", 32'(pending), 32'h0);
        check("rst_post_irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edge_det_bank.md
EDGE_DET_BANK -- requirements
Module: edge_det_bank

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel (2..4).
REQ-003 Parameter FILT_LEN, default 3, consecutive stable samples required before the filtered level changes (1..15).
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 Port signal_in, input, CH, asynchronous raw inputs, one bit per channel.
REQ-007 Port mode, input, 2*CH, per-channel detect mode in bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 Port irq_mask, input, CH, per-channel interrupt enable.
REQ-009 Port clr, input, CH, per-channel single-cycle clear strobe.
REQ-010 Port edge_rdy, output, CH, registered one-cycle edge pulse per channel.
REQ-011 Port pending, output, CH, sticky per-channel event flag.
REQ-012 Port irq, output, 1, registered OR of (pending & irq_mask).

Function
REQ-013 Each channel SHALL pass signal_in[i] through SYNC_STAGES flops before any other use.
REQ-014 Each channel SHALL hold a filtered level and a 4-bit stability counter.
- Counter increments while the synchroniser output differs from the filtered level.
- Counter clears to 0 on any cycle where they match.
REQ-015 The filtered level SHALL take the synchroniser value on the clock edge at which the differing value has been sampled FILT_LEN consecutive times; the counter SHALL clear on that same edge.
REQ-016 edge_rdy[i] SHALL be high for exactly one cycle, registered in the same cycle the filtered level changes, when that change matches mode[i]: 0->1 for rise, 1->0 for fall, either for both.
REQ-017 For a clean step held stable, edge_rdy[i] SHALL rise SYNC_STAGES+FILT_LEN clock edges after the first edge that samples the new level.
REQ-018 Pulses shorter than FILT_LEN cycles after synchronisation SHALL produce no edge_rdy, no pending and no filtered-level change.
REQ-019 Mode 00 SHALL suppress edge_rdy and pending set; synchronisation and filtering continue.
REQ-020 A mode change SHALL take effect on the next clock edge and SHALL NOT generate or retract events retroactively.
REQ-021 pending[i] SHALL set on edge_rdy[i] and clear on clr[i].
REQ-022 When edge_rdy[i] and clr[i] coincide, pending[i] SHALL remain 1, so no event is lost.
REQ-023 irq SHALL be registered, lagging pending & irq_mask by one cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be reported in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously clear all synchroniser flops, filtered levels, counters, edge_rdy, pending and irq to 0.
REQ-026 An input held high through reset release SHALL produce one rise event after SYNC_STAGES+FILT_LEN edges if its mode includes rise; this behaviour is intended.
REQ-027 Reset asserted mid-filtering SHALL discard the partial count and any pending event.

Configuration
REQ-028 Macro EDGE_DET_BANK_CNT_EN, when defined, SHALL add output cnt_out of width 8*CH, holding one 8-bit event counter per channel.
- Counter increments on edge_rdy[i] and saturates at 255.
- clr[i] clears the counter to 0; on coincident edge and clr the result SHALL be 1.
- Counters reset to 0.
REQ-029 Without EDGE_DET_BANK_CNT_EN, port cnt_out and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (CH=4, SYNC_STAGES=2, FILT_LEN=3)
REQ-030 Bench SHALL cover: mode=01, step signal_in[0] 0->1 held 10 cycles -> edge_rdy[0] high for 1 cycle, exactly 5 edges after the first sampling edge; pending[0]=1; irq=1 one cycle later with irq_mask[0]=1.
REQ-031 Bench SHALL cover: mode=11, 2-cycle high glitch on signal_in[1] -> no edge_rdy[1] and pending[1]=0.
REQ-032 Bench SHALL cover: mode=10, clr[2] pulsed in the same cycle as edge_rdy[2] -> pending[2] stays 1; a later clr[2] alone -> pending[2]=0.
REQ-033 Bench SHALL cover: all channels in mode 11 toggled together -> four simultaneous edge_rdy pulses; with irq_mask=0000, irq remains 0.
REQ-034 Bench SHALL cover: with EDGE_DET_BANK_CNT_EN, 300 qualified edges on channel 3 -> cnt_out[31:24]=255; a clr[3] pulse -> 0.
REQ-035 Bench SHALL cover: rst_n asserted 2 cycles into filtering -> all outputs 0 and no event after release while the input is low.
